// File: rtl/regfile_scan_display.sv
// Walks a register file one entry at a time and shows each 16-bit value on four active-low 7-seg digits.
// Auto mode dwells a fixed number of cycles per register; manual mode advances on a synchronized Step press.
module regfile_scan_display #(
   parameter int DWELL_CYCLES = 50_000_000,
   parameter int NUM_REGS     = 16,
   parameter int ADDR_W       = 4
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Start,
   input  logic              Mode,
   input  logic              Step_n,
   output logic              RegRdEn,
   output logic [ADDR_W-1:0] RegAddr,
   input  logic [15:0]       RegData,
   output logic [ADDR_W-1:0] RegIdx,
   output logic              Busy,
   output logic              Done,
   output logic [6:0]        out1,
   output logic [6:0]        out2,
   output logic [6:0]        out3,
   output logic [6:0]        out4
);

   localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);
   localparam logic [6:0]        SEG_BLANK  = 7'b1111111;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_SHOW    = 3'd3,
      ST_ADVANCE = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   state_t            state_r, state_s;
   logic [ADDR_W-1:0] idx_r, idx_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic              step_sync1_r, step_sync2_r, step_prev_r, step_pulse_r;
   logic              rd_en_r, busy_r, done_r;
   logic [ADDR_W-1:0] addr_r, reg_idx_r;
   logic [6:0]        seg1_r, seg2_r, seg3_r, seg4_r;

   // Hex nibble to active-low segments {g,f,e,d,c,b,a}
   function automatic logic [6:0] seg7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0011000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b0100111;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         4'hF:    s = 7'b0001110;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Step button: two-flop synchronizer, then registered falling-edge pulse
   always_ff @(posedge Clk) begin
      if (Rst) begin
         step_sync1_r <= 1'b1;
         step_sync2_r <= 1'b1;
         step_prev_r  <= 1'b1;
         step_pulse_r <= 1'b0;
      end else begin
         step_sync1_r <= Step_n;
         step_sync2_r <= step_sync1_r;
         step_prev_r  <= step_sync2_r;
         step_pulse_r <= step_prev_r & ~step_sync2_r;
      end
   end

   // Scan sequencer next-state, index and dwell count
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      cnt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (Start) begin
               state_s = ST_ISSUE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: state_s = ST_CAPTURE;
         ST_CAPTURE: begin
            cnt_s   = '0;
            state_s = ST_SHOW;
         end
         ST_SHOW: begin
            // Count is held while in manual mode so a return to auto resumes it
            if (Mode) begin
               if (cnt_r == DWELL_LAST) begin
                  state_s = ST_ADVANCE;
               end else begin
                  cnt_s = cnt_r + CNT_W'(1);
               end
            end else begin
               if (step_pulse_r) begin
                  state_s = ST_ADVANCE;
               end else begin
                  state_s = ST_SHOW;
               end
            end
         end
         ST_ADVANCE: begin
            if (idx_r == LAST_IDX) begin
               state_s = ST_DONE;
            end else begin
               idx_s   = idx_r + ADDR_W'(1);
               state_s = ST_ISSUE;
            end
         end
         ST_DONE: begin
            idx_s   = '0;
            state_s = ST_IDLE;
         end
         default: begin
            idx_s   = '0;
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, read-port outputs, status flags and captured display
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_r   <= ST_IDLE;
         idx_r     <= '0;
         cnt_r     <= '0;
         rd_en_r   <= 1'b0;
         addr_r    <= '0;
         reg_idx_r <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         seg1_r    <= SEG_BLANK;
         seg2_r    <= SEG_BLANK;
         seg3_r    <= SEG_BLANK;
         seg4_r    <= SEG_BLANK;
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
         cnt_r   <= cnt_s;
         rd_en_r <= (state_s == ST_ISSUE);
         busy_r  <= (state_s == ST_ISSUE) || (state_s == ST_CAPTURE) ||
                    (state_s == ST_SHOW)  || (state_s == ST_ADVANCE);
         done_r  <= (state_s == ST_DONE);
         if (state_s == ST_ISSUE) begin
            addr_r <= idx_s;
         end
         // Read data arrives one cycle after the strobe, i.e. during CAPTURE
         if (state_r == ST_CAPTURE) begin
            reg_idx_r <= idx_r;
            seg1_r    <= seg7(RegData[15:12]);
            seg2_r    <= seg7(RegData[11:8]);
            seg3_r    <= seg7(RegData[7:4]);
            seg4_r    <= seg7(RegData[3:0]);
         end
      end
   end

   assign RegRdEn = rd_en_r;
   assign RegAddr = addr_r;
   assign RegIdx  = reg_idx_r;
   assign Busy    = busy_r;
   assign Done    = done_r;
   assign out1    = seg1_r;
   assign out2    = seg2_r;
   assign out3    = seg3_r;
   assign out4    = seg4_r;

endmodule
